// File: rtl/calc_pkg.sv
// Shared encodings and constants for the calculator BCD datapath.
package calc_pkg;

    localparam int DIGITS_DEFAULT = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [3:0] nines_comp(input logic [3:0] d);
        return BCD_MAX - d;
    endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Single-digit BCD adder with decimal correction; shared by the add and complement passes.
module bcd_digit_adder
    import calc_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] raw;

    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        sum  = raw[3:0];
        cout = 1'b0;
        if (raw > {1'b0, BCD_MAX}) begin
            sum  = raw[3:0] + BCD_CORR;
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Digit-serial BCD add/subtract sequencer: one shared digit adder walks the digits LSD first,
// with a ten's-complement pass when a subtraction comes out negative.
module alu_sequencer
    import calc_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  start,
    input  logic                  op,
    input  logic [4*DIGITS-1:0]   a_bcd,
    input  logic [4*DIGITS-1:0]   b_bcd,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   result_bcd,
    output logic                  neg,
    output logic                  ovf,
    output logic                  err
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t               state_reg, state_next;
    logic                 op_reg;
    logic [4*DIGITS-1:0]  a_reg, b_reg;
    logic [IDX_W-1:0]     idx_reg;
    logic                 carry_reg;
    logic [3:0]           result_dig_reg [DIGITS];
    logic                 busy_reg, done_reg, neg_reg, ovf_reg, err_reg;
    logic                 busy_next, done_next;

    logic [3:0]           a_dig [DIGITS];
    logic [3:0]           b_dig [DIGITS];
    logic [DIGITS-1:0]    dig_bad;
    logic                 any_bad;
    logic                 last_digit;
    logic [3:0]           add_a, add_b, add_sum;
    logic                 add_cout;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digits
            assign a_dig[gi]   = a_reg[4*gi +: 4];
            assign b_dig[gi]   = b_reg[4*gi +: 4];
            assign dig_bad[gi] = (a_dig[gi] > BCD_MAX) || (b_dig[gi] > BCD_MAX);
            assign result_bcd[4*gi +: 4] = result_dig_reg[gi];
        end
    endgenerate

    assign any_bad    = |dig_bad;
    assign last_digit = (idx_reg == LAST_IDX);

    // FIX feeds (9-d) with a zero addend so the carry completes the ten's complement.
    always_comb begin
        add_a = a_dig[idx_reg];
        add_b = (op_reg == OP_SUB) ? nines_comp(b_dig[idx_reg]) : b_dig[idx_reg];
        if (state_reg == ST_FIX) begin
            add_a = nines_comp(result_dig_reg[idx_reg]);
            add_b = 4'd0;
        end
    end

    bcd_digit_adder u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_reg),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operand validity is judged on the latched digits during the first ADD cycle,
    // which gives the error path its two-cycle latency.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_ADD;
            ST_ADD: begin
                if (any_bad) begin
                    state_next = ST_DONE;
                end else if (last_digit) begin
                    state_next = (op_reg == OP_SUB && !add_cout) ? ST_FIX : ST_DONE;
                end
            end
            ST_FIX:  if (last_digit) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (clr) state_next = ST_IDLE;
    end

    always_comb begin
        busy_next = (state_next != ST_IDLE);
        done_next = (state_next == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            op_reg    <= OP_ADD;
            a_reg     <= '0;
            b_reg     <= '0;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            neg_reg   <= 1'b0;
            ovf_reg   <= 1'b0;
            err_reg   <= 1'b0;
            for (int i = 0; i < DIGITS; i++) result_dig_reg[i] <= 4'd0;
        end else begin
            busy_reg <= busy_next;
            done_reg <= done_next;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        op_reg    <= op;
                        a_reg     <= a_bcd;
                        b_reg     <= b_bcd;
                        idx_reg   <= '0;
                        carry_reg <= op;
                        neg_reg   <= 1'b0;
                        ovf_reg   <= 1'b0;
                        err_reg   <= 1'b0;
                        for (int i = 0; i < DIGITS; i++) result_dig_reg[i] <= 4'd0;
                    end
                end
                ST_ADD: begin
                    if (any_bad) begin
                        err_reg <= 1'b1;
                    end else begin
                        result_dig_reg[idx_reg] <= add_sum;
                        carry_reg <= add_cout;
                        idx_reg   <= last_digit ? '0 : idx_reg + 1'b1;
                        if (last_digit) begin
                            if (op_reg == OP_ADD) begin
                                ovf_reg <= add_cout;
                            end else if (!add_cout) begin
                                neg_reg   <= 1'b1;
                                carry_reg <= 1'b1;
                            end
                        end
                    end
                end
                ST_FIX: begin
                    result_dig_reg[idx_reg] <= add_sum;
                    carry_reg <= add_cout;
                    idx_reg   <= last_digit ? '0 : idx_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign neg  = neg_reg;
    assign ovf  = ovf_reg;
    assign err  = err_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: expected results are queued at start and checked on done.
module tb_alu_sequencer;

    localparam int DIGITS = 4;
    localparam int W = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         clr = 1'b0;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [W-1:0] a_bcd = '0;
    logic [W-1:0] b_bcd = '0;
    logic         busy, done, neg, ovf, err;
    logic [W-1:0] result_bcd;

    typedef struct {
        logic [W-1:0] res;
        logic         neg;
        logic         ovf;
        logic         err;
        int           due;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;

    alu_sequencer #(.DIGITS(DIGITS)) dut (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr),
        .start      (start),
        .op         (op),
        .a_bcd      (a_bcd),
        .b_bcd      (b_bcd),
        .busy       (busy),
        .done       (done),
        .result_bcd (result_bcd),
        .neg        (neg),
        .ovf        (ovf),
        .err        (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Done monitor: every done must match the oldest queued expectation, on its due cycle.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            done_cnt++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done cyc=%0d result=%h", cyc, result_bcd);
            end else begin
                e = sb.pop_front();
                if ({result_bcd, neg, ovf, err} !== {e.res, e.neg, e.ovf, e.err}) begin
                    bad++;
                    $display("FAIL done_result got res=%h neg=%b ovf=%b err=%b want res=%h neg=%b ovf=%b err=%b",
                             result_bcd, neg, ovf, err, e.res, e.neg, e.ovf, e.err);
                end
                total++;
                if (cyc != e.due) begin
                    bad++;
                    $display("FAIL done_latency got cyc=%0d want cyc=%0d", cyc, e.due);
                end
            end
        end
    end

    task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_res, input logic e_neg, input logic e_ovf,
                          input logic e_err, input int lat, input string name);
        exp_t e;
        @(negedge clk);
        e.res = exp_res; e.neg = e_neg; e.ovf = e_ovf; e.err = e_err; e.due = cyc + lat;
        sb.push_back(e);
        start = 1'b1; op = o; a_bcd = a; b_bcd = b;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL %s busy_cycle%0d got %b want 1", name, k, busy);
            end
        end
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL %s after_done got busy=%b done=%b want 0 0", name, busy, done);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s no_done got pending=%0d want 0", name, sb.size());
            sb.delete();
        end
        total++;
        if ({result_bcd, neg, ovf, err} !== {exp_res, e_neg, e_ovf, e_err}) begin
            bad++;
            $display("FAIL %s hold got res=%h neg=%b ovf=%b err=%b want res=%h neg=%b ovf=%b err=%b",
                     name, result_bcd, neg, ovf, err, exp_res, e_neg, e_ovf, e_err);
        end
        $display("txn %s op=%0d a=%h b=%h result=%h neg=%b ovf=%b err=%b",
                 name, o, a, b, result_bcd, neg, ovf, err);
    endtask

    task automatic check_cleared(input string name);
        total++;
        if ({busy, done, result_bcd, neg, ovf, err} !== '0) begin
            bad++;
            $display("FAIL %s cleared got busy=%b done=%b res=%h neg=%b ovf=%b err=%b want all 0",
                     name, busy, done, result_bcd, neg, ovf, err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_cleared("reset_release");
    endtask

    task automatic test_add();
        run_op(1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, 1'b0, 5, "add_1234_5678");
        run_op(1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0, 5, "add_9999_0001");
        run_op(1'b0, 16'h4321, 16'h1111, 16'h5432, 1'b0, 1'b0, 1'b0, 5, "add_4321_1111");
    endtask

    task automatic test_sub();
        run_op(1'b1, 16'h0050, 16'h0008, 16'h0042, 1'b0, 1'b0, 1'b0, 5, "sub_0050_0008");
        run_op(1'b1, 16'h0008, 16'h0050, 16'h0042, 1'b1, 1'b0, 1'b0, 9, "sub_0008_0050");
        run_op(1'b1, 16'h0777, 16'h0777, 16'h0000, 1'b0, 1'b0, 1'b0, 5, "sub_0777_0777");
        run_op(1'b1, 16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, 1'b0, 5, "sub_1000_0001");
        run_op(1'b1, 16'h0001, 16'h1000, 16'h0999, 1'b1, 1'b0, 1'b0, 9, "sub_0001_1000");
    endtask

    task automatic test_err();
        run_op(1'b0, 16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 2, "err_a_12A4");
        run_op(1'b1, 16'h0005, 16'h0B00, 16'h0000, 1'b0, 1'b0, 1'b1, 2, "err_b_0B00");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int d0;
        d0 = done_cnt;
        @(negedge clk);
        e.res = 16'h3333; e.neg = 1'b0; e.ovf = 1'b0; e.err = 1'b0; e.due = cyc + 5;
        sb.push_back(e);
        start = 1'b1; op = 1'b0; a_bcd = 16'h1111; b_bcd = 16'h2222;
        @(posedge clk); #1;
        op = 1'b1; a_bcd = 16'h9999; b_bcd = 16'h0001;
        @(posedge clk); @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(negedge clk);
        total++;
        if (done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL ignored_start done_count got %0d want 1", done_cnt - d0);
        end
        total++;
        if (sb.size() != 0 || result_bcd !== 16'h3333) begin
            bad++;
            $display("FAIL ignored_start result got res=%h pending=%0d want res=3333 pending=0",
                     result_bcd, sb.size());
            sb.delete();
        end
        $display("txn ignored_start a=1111 b=2222 result=%h", result_bcd);
        run_op(1'b0, 16'h9000, 16'h0999, 16'h9999, 1'b0, 1'b0, 1'b0, 5, "b2b_first");
        run_op(1'b1, 16'h0000, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, 9, "b2b_second");
    endtask

    task automatic test_clr();
        int d0;
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; op = 1'b1; a_bcd = 16'h0008; b_bcd = 16'h0050;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check_cleared("clr_mid_sub");
        repeat (12) @(negedge clk);
        total++;
        if (done_cnt != d0) begin
            bad++;
            $display("FAIL clr_no_done got %0d dones want 0", done_cnt - d0);
        end
        $display("txn clr_mid_sub result=%h busy=%b", result_bcd, busy);
        run_op(1'b1, 16'h0008, 16'h0050, 16'h0042, 1'b1, 1'b0, 1'b0, 9, "pre_clr_idle");
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check_cleared("clr_idle");
        $display("txn clr_idle result=%h neg=%b", result_bcd, neg);
    endtask

    task automatic test_reset_mid();
        int d0;
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; op = 1'b1; a_bcd = 16'h0008; b_bcd = 16'h0050;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; start = 1'b1; op = 1'b0; a_bcd = 16'h0001; b_bcd = 16'h0001;
        @(posedge clk); #1;
        check_cleared("reset_mid_fix");
        @(posedge clk); #1;
        check_cleared("reset_held_start");
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_cleared("reset_idle");
        repeat (10) @(negedge clk);
        total++;
        if (done_cnt != d0) begin
            bad++;
            $display("FAIL reset_no_done got %0d dones want 0", done_cnt - d0);
        end
        $display("txn reset_mid_fix result=%h busy=%b", result_bcd, busy);
        run_op(1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 5, "after_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_err();
        test_back_to_back();
        test_clr();
        test_reset_mid();
        repeat (3) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL leftover_expected got %0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Digit-serial BCD add/subtract sequencer for the calculator datapath. Once the key-interpretation FSM has loaded both operands and the operator, it pulses `start`. The block then schedules one shared single-digit BCD adder across all digits and, for negative differences, runs a second complement pass. It returns a registered magnitude, sign and overflow flags to the result register / display path with a start/busy/done handshake.

## Interface
- `DIGITS`, 4: number of BCD digits per operand and per result.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low; sampled on `clk` rising edge.
- `clr`  in  1  synchronous abort/clear from the reset key (active high).
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  1  0 = add (A+B), 1 = subtract (A−B); latched with `start`.
- `a_bcd`  in  4*DIGITS  operand A, digit 0 = bits [3:0] (LSD); latched with `start`.
- `b_bcd`  in  4*DIGITS  operand B, same layout; latched with `start`.
- `busy`  out  1  high from the cycle after `start` acceptance through the DONE cycle.
- `done`  out  1  one-cycle pulse; result outputs valid.
- `result_bcd`  out  4*DIGITS  magnitude of the result.
- `neg`  out  1  result negative (subtract with A<B).
- `ovf`  out  1  add carried out of the MSD.
- `err`  out  1  an operand held a digit > 9.

## Operation
- States: IDLE, ADD, FIX, DONE.
- IDLE:
  - `start`=1 latches `op`, `a_bcd` and `b_bcd`, and clears `neg`, `ovf`, `err`.
  - Any latched digit > 9: go to DONE with `err`=1 and `result_bcd`=0.
  - Otherwise go to ADD with digit index 0 and carry = `op`.
- ADD: one digit per cycle, LSD first.
  - Operand digit b is b (add) or 9−b (subtract).
  - Per-digit sum s = a + b' + carry; if s > 9, digit = s+6 (low 4 bits) and carry = 1.
  - After digit DIGITS−1:
    - add: `ovf` = final carry; go to DONE.
    - subtract, final carry 1: A≥B, result as computed; go to DONE.
    - subtract, final carry 0: `neg`=1; go to FIX with index 0 and carry 1.
- FIX: one digit per cycle, LSD first; each result digit is replaced by (9−d)+carry through the same adder (ten's complement). After the last digit, go to DONE.
- DONE: `done`=1 for one cycle; go to IDLE.
- `result_bcd`, `neg`, `ovf` and `err` hold until the next accepted `start`, `clr` or `reset`.
- Subtract never sets `ovf`. A−A gives 0 with `neg`=0.
- `start` while not in IDLE is ignored; no queuing.
- Priority: `reset` > `clr` > `start`.
- `clr` or `reset` in any state: go to IDLE and clear all outputs to 0. An in-flight operation is discarded with no `done`.

## Timing
- E0 is the rising edge that samples `start`=1 in IDLE.
- Add, or subtract with A≥B: digits processed at E1..E_DIGITS; `done` high in the cycle after E_DIGITS. Latency DIGITS+1 cycles (5 for DIGITS=4).
- Subtract with A<B: FIX runs E(DIGITS+1)..E(2·DIGITS); `done` high after E(2·DIGITS). Latency 2·DIGITS+1 (9).
- `err` path: `done` high in the cycle after E1. Latency 2.
- `busy` falls at the edge that ends DONE. A new `start` is accepted on the same edge that `busy` is observed low.
- Reset values: `busy`=0, `done`=0, `result_bcd`=0, `neg`=0, `ovf`=0, `err`=0, state IDLE.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `calc_pkg`:
  - op encodings `OP_ADD`=0 and `OP_SUB`=1.
  - state encoding, 2 bits.
  - `BCD_MAX`=9, `BCD_CORR`=6.
  - default DIGITS.
- Sub-module `bcd_digit_adder`: combinational, 4b a, 4b b, cin → 4b sum, cout. It is the single shared instance, used by both ADD and FIX.
- The digit index counter is ⌈log2 DIGITS⌉ bits wide.

## Test plan
- add 1234+5678 → `result_bcd`=6912, `neg`=0, `ovf`=0, `done` 5 cycles after E0, `busy` high in cycles 1–5.
- add 9999+0001 → `result_bcd`=0000, `ovf`=1, latency 5.
- sub 0050−0008 → 0042 with `neg`=0, latency 5; sub 0008−0050 → 0042 with `neg`=1, latency 9; sub 0777−0777 → 0000 with `neg`=0.
- `a_bcd`=12A4 with add → `err`=1, `result_bcd`=0, `done` 2 cycles after E0.
- Second `start` at cycle 2 of a busy add → ignored, exactly one `done`. Then `clr` at cycle 3 of a subtract → IDLE next edge, all outputs 0, no `done`.
- `reset` low mid-FIX while `start` is high → all outputs 0 and state IDLE. After `reset` goes high, 0001+0001 gives 0002.
